// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the fetch-stage program-counter
// generator.
//   pc_state_t      fetch FSM states (S_OFF, S_IDLE, S_REQ)
//   *_DEF           default PC width, instruction step and reset vector
//   align_mask()    mask that clears the sub-instruction address bits
package pc_pkg;

    typedef enum logic [1:0] {
        S_OFF,
        S_IDLE,
        S_REQ
    } pc_state_t;

    localparam int unsigned PC_WIDTH_DEF     = 32;
    localparam int unsigned INSTR_BYTES_DEF  = 4;
    localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;

    // Mask with the low log2(instr_bytes) bits cleared. It is 64 bits wide;
    // callers size-cast it to their PC width, which must not exceed 64.
    function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
        return ~(64'(instr_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// pc_redirect_hold: buffers a redirect that arrives while a fetch request is
// outstanding, and selects the PC to load once the PC is allowed to move.
//   clk, rst        clock, asynchronous active-high reset
//   pc              current PC
//   branch          redirect strobe this cycle
//   branch_target   redirect address (unaligned allowed)
//   capture         store branch_target as the pending redirect
//   consume         the PC is loading next_pc this cycle; drop any pending one
//   next_pc         branch target > pending target > pc + STEP
//   pending         a buffered redirect is waiting
module pc_redirect_hold import pc_pkg::*; #(
    parameter int unsigned             PC_WIDTH   = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]     STEP       = PC_WIDTH'(INSTR_BYTES_DEF),
    parameter logic [PC_WIDTH-1:0]     ALIGN_MASK = PC_WIDTH'(align_mask(INSTR_BYTES_DEF))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                capture,
    input  logic                consume,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                pending
);

    logic [PC_WIDTH-1:0] pending_target;

    // A newer capture simply overwrites the stored target (newest wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending        <= 1'b0;
            pending_target <= '0;
        end else if (consume) begin
            pending        <= 1'b0;
        end else if (capture) begin
            pending        <= 1'b1;
            pending_target <= branch_target & ALIGN_MASK;
        end
    end

    always_comb begin
        next_pc = pc + STEP;
        if (branch) begin
            next_pc = branch_target & ALIGN_MASK;
        end else if (pending) begin
            next_pc = pending_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage. Holds the PC,
// presents it as a fetch request over valid/ready, advances it by
// INSTR_BYTES per accepted request and applies branch redirects. A redirect
// that arrives while a request is outstanding is buffered so the presented
// address never changes until the handshake completes.
//   clk, rst             clock, asynchronous active-high reset
//   stall_i              pipeline stall, suppresses new requests
//   branch_i             one-cycle redirect strobe
//   branch_target_i      redirect address
//   fetch_ready_i        memory accepts the current request
//   ce_o                 fetch enable (low in reset and the cycle after)
//   fetch_valid_o        request valid
//   pc_o                 current PC / fetch address
//   redirect_pending_o   a buffered redirect is waiting
module pc_gen import pc_pkg::*; #(
    parameter int unsigned         PC_WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned         INSTR_BYTES  = INSTR_BYTES_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                branch_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    input  logic                fetch_ready_i,
    output logic                ce_o,
    output logic                fetch_valid_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                redirect_pending_o
);

    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(align_mask(INSTR_BYTES));

    pc_state_t           state;
    pc_state_t           state_next;
    logic                load_pc;
    logic                capture;
    logic                handshake;
    logic [PC_WIDTH-1:0] next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_OFF;
        end else begin
            state <= state_next;
        end
    end

    // An outstanding request (S_REQ without ready) freezes the PC and the
    // state; stall and redirects are only acted on once it is accepted.
    always_comb begin
        state_next = state;
        handshake  = 1'b0;
        load_pc    = 1'b0;
        capture    = 1'b0;
        case (state)
            S_OFF: begin
                state_next = stall_i ? S_IDLE : S_REQ;
            end
            S_IDLE: begin
                load_pc = branch_i;
                if (!stall_i) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (fetch_ready_i) begin
                    handshake  = 1'b1;
                    load_pc    = 1'b1;
                    state_next = stall_i ? S_IDLE : S_REQ;
                end else begin
                    capture = branch_i;
                end
            end
            default: begin
                state_next = S_OFF;
            end
        endcase
    end

    pc_redirect_hold #(
        .PC_WIDTH   (PC_WIDTH),
        .STEP       (STEP),
        .ALIGN_MASK (ALIGN_MASK)
    ) u_hold (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc_o),
        .branch        (branch_i),
        .branch_target (branch_target_i),
        .capture       (capture),
        .consume       (handshake),
        .next_pc       (next_pc),
        .pending       (redirect_pending_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_o <= RESET_VECTOR;
        end else if (load_pc) begin
            pc_o <= next_pc;
        end
    end

    assign ce_o          = (state != S_OFF);
    assign fetch_valid_o = (state == S_REQ);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h100;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        fetch_ready_i;
    logic        ce_o;
    logic        fetch_valid_o;
    logic [31:0] pc_o;
    logic        redirect_pending_o;

    int unsigned tests;
    int unsigned fails;

    pc_gen #(
        .PC_WIDTH     (32),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (RV)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall_i),
        .branch_i           (branch_i),
        .branch_target_i    (branch_target_i),
        .fetch_ready_i      (fetch_ready_i),
        .ce_o               (ce_o),
        .fetch_valid_o      (fetch_valid_o),
        .pc_o               (pc_o),
        .redirect_pending_o (redirect_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: "on" = fetch enabled, "busy" = a request is being presented.
    bit          m_on;
    bit          m_busy;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on = 0; m_busy = 0; m_pc = RV; m_pend = 0; m_tgt = '0;
        end else if (!m_on) begin
            m_on   = 1;
            m_busy = !stall_i;
        end else if (!m_busy) begin
            if (branch_i) m_pc = aligned(branch_target_i);
            if (!stall_i) m_busy = 1;
        end else if (fetch_ready_i) begin
            if (branch_i)     m_pc = aligned(branch_target_i);
            else if (m_pend)  m_pc = m_tgt;
            else              m_pc = m_pc + 32'd4;
            m_pend = 0;
            m_busy = !stall_i;
        end else if (branch_i) begin
            m_pend = 1;
            m_tgt  = aligned(branch_target_i);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_ce",      32'(ce_o),               32'(m_on));
            check("model_valid",   32'(fetch_valid_o),      32'(m_busy));
            check("model_pc",      pc_o,                    m_pc);
            check("model_pending", 32'(redirect_pending_o), 32'(m_pend));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0;
        branch_target_i = '0; fetch_ready_i = 1'b1;

        #1;
        check("reset_ce",      32'(ce_o), 32'd0);
        check("reset_valid",   32'(fetch_valid_o), 32'd0);
        check("reset_pc",      pc_o, RV);
        check("reset_pending", 32'(redirect_pending_o), 32'd0);

        // Release reset mid-cycle; enable and valid rise together.
        tick; rst = 1'b0;
        tick;
        check("rel_ce",    32'(ce_o), 32'd1);
        check("rel_valid", 32'(fetch_valid_o), 32'd1);
        check("rel_pc0",   pc_o, 32'h100);
        tick; check("rel_pc1", pc_o, 32'h104);
        tick; check("rel_pc2", pc_o, 32'h108);

        // Three cycles without ready, branch in the second one.
        fetch_ready_i = 1'b0;
        tick;
        branch_i = 1'b1; branch_target_i = 32'h2000;
        tick;
        branch_i = 1'b0;
        tick;
        check("buf_pc_held", pc_o, 32'h108);
        check("buf_pending", 32'(redirect_pending_o), 32'd1);
        fetch_ready_i = 1'b1;
        tick;
        check("buf_pc_tgt",  pc_o, 32'h2000);
        check("buf_cleared", 32'(redirect_pending_o), 32'd0);

        // Two branches during one wait: the newest one wins.
        fetch_ready_i = 1'b0;
        branch_i = 1'b1; branch_target_i = 32'h2000;
        tick;
        branch_target_i = 32'h3000;
        tick;
        branch_i = 1'b0; fetch_ready_i = 1'b1;
        tick;
        check("newest_wins", pc_o, 32'h3000);

        // Stall through a handshake to reach idle, then an unaligned branch.
        stall_i = 1'b1;
        tick;
        check("idle_valid", 32'(fetch_valid_o), 32'd0);
        check("idle_pc",    pc_o, 32'h3004);
        branch_i = 1'b1; branch_target_i = 32'h2003;
        tick;
        check("idle_branch_align", pc_o, 32'h2000);
        branch_i = 1'b0; stall_i = 1'b0;
        tick;
        check("unstall_valid", 32'(fetch_valid_o), 32'd1);

        // Wrap at the top of the address space.
        branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        tick;
        check("wrap_top", pc_o, 32'hFFFF_FFFC);
        branch_i = 1'b0;
        tick;
        check("wrap_zero", pc_o, 32'h0);

        // Stall cannot withdraw an outstanding request.
        fetch_ready_i = 1'b0; stall_i = 1'b1;
        tick; tick;
        check("stall_hold_valid", 32'(fetch_valid_o), 32'd1);
        fetch_ready_i = 1'b1;
        tick;
        check("stall_drop_valid", 32'(fetch_valid_o), 32'd0);
        check("stall_pc",         pc_o, 32'h4);
        stall_i = 1'b0;
        tick;
        check("stall_release", 32'(fetch_valid_o), 32'd1);

        // Asynchronous reset with a pending redirect and an outstanding request.
        fetch_ready_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h5000;
        tick;
        branch_i = 1'b0;
        rst = 1'b1;
        #1;
        check("async_pc",      pc_o, RV);
        check("async_ce",      32'(ce_o), 32'd0);
        check("async_valid",   32'(fetch_valid_o), 32'd0);
        check("async_pending", 32'(redirect_pending_o), 32'd0);
        tick; tick;
        rst = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            stall_i         = ($urandom_range(0, 3) == 0);
            branch_i        = ($urandom_range(0, 4) == 0);
            branch_target_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : $urandom;
            fetch_ready_i   = ($urandom_range(0, 9) < 7);
            rst             = ($urandom_range(0, 299) == 0);
            tick;
        end
        rst = 1'b0; branch_i = 1'b0;
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage: it holds the PC, issues fetch requests to instruction memory over a valid/ready handshake, and accepts stall and branch-redirect inputs from the pipeline. It extends the fixed 6-bit increment-only PC with configurable width, reset vector and instruction step. It also adds redirect buffering so that the address presented with an outstanding request never changes. It sits between pipeline control (stall and branch from decode/execute) and the instruction-memory port.

## Interface
- PC_WIDTH, 32: PC and address width in bits; minimum 4.
- INSTR_BYTES, 4: PC step per accepted fetch; power of two, ≤ 2^(PC_WIDTH-1).
- RESET_VECTOR, 0: PC value while disabled and after reset; must be INSTR_BYTES-aligned.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall_i  in  1  pipeline stall; suppresses new requests.
- branch_i  in  1  redirect strobe, valid for one cycle.
- branch_target_i  in  PC_WIDTH  redirect address.
- fetch_ready_i  in  1  memory accepts the current request.
- ce_o  out  1  fetch enable; 0 in reset and in the first cycle after reset.
- fetch_valid_o  out  1  request valid.
- pc_o  out  PC_WIDTH  current PC, also the fetch address.
- redirect_pending_o  out  1  a buffered redirect is waiting.

## Operation
- States:
  - S_OFF: ce_o=0, valid=0.
  - S_IDLE: ce_o=1, valid=0.
  - S_REQ: ce_o=1, valid=1.
- Reset values: state S_OFF, ce_o=0, fetch_valid_o=0, pc_o=RESET_VECTOR, redirect_pending_o=0, pending target=0.
- S_OFF transitions at the first edge with rst low: goes to S_IDLE if stall_i, else S_REQ. pc_o stays RESET_VECTOR.
- S_IDLE → S_REQ when !stall_i. Otherwise stays.
- S_REQ, handshake (fetch_ready_i=1):
  - pc_o loads next_pc.
  - Next state is S_IDLE if stall_i, else S_REQ.
- S_REQ, no handshake: stays in S_REQ. pc_o is held, and stall_i is ignored, because a request cannot be withdrawn.
- next_pc priority:
  1. branch_i this cycle → branch_target_i.
  2. Pending redirect → pending target; clears pending.
  3. Otherwise pc_o + INSTR_BYTES.
- Redirect with no outstanding request (S_IDLE, or S_REQ with handshake): applied directly. pc_o = target at the next edge.
- Redirect in S_REQ without handshake: target is captured and redirect_pending_o set. A later branch_i before the handshake overwrites the captured target (newest wins).
- Branch in S_OFF: ignored.
- Target alignment: low log2(INSTR_BYTES) bits of any loaded target are forced to 0.
- Arithmetic: increment is modulo 2^PC_WIDTH. The maximum aligned PC wraps to 0 with no flag.
- Asynchronous rst mid-request: all outputs take reset values immediately. The outstanding request is dropped, and memory must discard it.

## Timing
- Reset release: ce_o and fetch_valid_o rise at the first edge after rst falls, with pc_o=RESET_VECTOR.
- Throughput: one fetch per cycle while !stall_i and fetch_ready_i=1.
- Redirect latency: a direct redirect appears on pc_o one cycle after branch_i. A buffered redirect appears at the edge completing the outstanding handshake.
- pc_o and fetch_valid_o are registered outputs, with no combinational path from inputs.
- stall_i asserted in the handshake cycle drops valid at the next edge. Deasserting stall raises valid at the following edge.

## Structure
- Shared package pc_pkg holds:
  - pc_state_t enum (S_OFF, S_IDLE, S_REQ);
  - default PC_WIDTH, INSTR_BYTES and RESET_VECTOR constants;
  - an alignment-mask function.
- Single module, no sub-module required. The pending-redirect register and next_pc priority mux may live in one optional sub-module, pc_redirect_hold.

## Test plan
All scenarios use PC_WIDTH=32, INSTR_BYTES=4, RESET_VECTOR=0x100.
- Reset release, ready tied 1, no stall → ce_o and valid rise together; pc_o sequence is 0x100, 0x104, 0x108.
- Ready low for 3 cycles at pc 0x108 while branch_i pulses target 0x2000 in the second of those cycles → pc_o holds 0x108 and redirect_pending_o=1. After ready, pc_o=0x2000 and pending clears.
- Two branches during one wait (0x2000, then 0x3000) → after the handshake pc_o=0x3000.
- branch_i target 0x2003 in S_IDLE → pc_o=0x2000.
- pc_o=0xFFFF_FFFC with handshake → pc_o=0x0000_0000.
- stall_i asserted while valid=1 and ready=0 → valid stays 1 until ready. Then state goes to S_IDLE and valid=0. Asynchronous rst mid-request forces pc_o=0x100 and ce_o=0 without a clock edge.
